// File: rtl/interface_spimaster_if.sv
// Host-side handshake bundle for interface_spimaster: frame request/data in, received frame and status out.
interface interface_spimaster_if #(
  parameter int unsigned BUFFER_SIZE = 64
);
  logic                   start;
  logic [BUFFER_SIZE-1:0] tx_data;
  logic [BUFFER_SIZE-1:0] rx_data;
  logic                   rx_valid;
  logic                   frame_error;
  logic                   busy;

  // Host that requests frames.
  modport master (
    output start, tx_data,
    input  rx_data, rx_valid, frame_error, busy
  );

  // The SPI master engine serving the host.
  modport slave (
    input  start, tx_data,
    output rx_data, rx_valid, frame_error, busy
  );
endinterface

// File: rtl/interface_spimaster.sv
// Full-duplex SPI master for the LinuxCNC-RIO link: one BUFFER_SIZE-bit frame per request, MSGID-checked rx, link timeout.
// Optional macro SPI_MASTER_AUTOSTART_EN: back-to-back frames without waiting for start.
module interface_spimaster #(
  parameter int unsigned BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned GAP         = 8,
  parameter logic [31:0] TIMEOUT     = 32'd4800000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  interface_spimaster_if.slave  bus,
  output logic                  SPI_SCK,
  output logic                  SPI_SSEL,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO,
  output logic                  pkg_timeout
);
  localparam int unsigned BW = $clog2(BUFFER_SIZE + 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BUFFER_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

  state_t                 state, state_n;
  logic [15:0]            cnt, cnt_n;
  logic [BW-1:0]          bitcnt, bitcnt_n;
  logic [BUFFER_SIZE-1:0] tx_shift, tx_n, rx_shift, rx_n, rx_data_q, rxd_n;
  logic                   sck_n, ssel_n, mosi_n, rxv_q, rxv_n, ferr_q, ferr_n, busy_q, busy_n;
  logic                   miso_meta, miso_sync, frame_ok, go;
  logic [31:0]            to_cnt;

`ifdef SPI_MASTER_AUTOSTART_EN
  assign go = 1'b1;
`else
  assign go = bus.start;
`endif

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rxv_q;
  assign bus.frame_error = ferr_q;
  assign bus.busy        = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data_q   <= '0;
      rxv_q       <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
      SPI_SCK     <= 1'b0;
      SPI_SSEL    <= 1'b1;
      SPI_MOSI    <= 1'b0;
      miso_meta   <= 1'b0;
      miso_sync   <= 1'b0;
      to_cnt      <= '0;
      pkg_timeout <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bitcnt    <= bitcnt_n;
      tx_shift  <= tx_n;
      rx_shift  <= rx_n;
      rx_data_q <= rxd_n;
      rxv_q     <= rxv_n;
      ferr_q    <= ferr_n;
      busy_q    <= busy_n;
      SPI_SCK   <= sck_n;
      SPI_SSEL  <= ssel_n;
      SPI_MOSI  <= mosi_n;
      miso_meta <= SPI_MISO;
      miso_sync <= miso_meta;
      // Flag is sticky from reset until the first good frame, then tracks the saturating counter.
      if (frame_ok) begin
        to_cnt      <= '0;
        pkg_timeout <= 1'b0;
      end else if (to_cnt < TIMEOUT) begin
        to_cnt <= to_cnt + 32'd1;
        if (to_cnt + 32'd1 >= TIMEOUT) pkg_timeout <= 1'b1;
      end else begin
        pkg_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    tx_n     = tx_shift;
    rx_n     = rx_shift;
    rxd_n    = rx_data_q;
    rxv_n    = 1'b0;
    ferr_n   = 1'b0;
    busy_n   = busy_q;
    sck_n    = SPI_SCK;
    ssel_n   = SPI_SSEL;
    mosi_n   = SPI_MOSI;
    frame_ok = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          tx_n     = bus.tx_data;
          ssel_n   = 1'b0;
          busy_n   = 1'b1;
          mosi_n   = bus.tx_data[BUFFER_SIZE-1];
          cnt_n    = '0;
          bitcnt_n = '0;
          state_n  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = S_LOW;
        end else cnt_n = cnt + 16'd1;
      end
      S_LOW: begin
        sck_n  = 1'b0;
        mosi_n = tx_shift[BUFFER_SIZE-1];
        if (cnt == DIV_LAST) begin
          cnt_n   = '0;
          sck_n   = 1'b1;
          state_n = S_HIGH;
        end else cnt_n = cnt + 16'd1;
      end
      S_HIGH: begin
        if (cnt == DIV_LAST) begin
          cnt_n    = '0;
          rx_n     = {rx_shift[BUFFER_SIZE-2:0], miso_sync};
          tx_n     = {tx_shift[BUFFER_SIZE-2:0], 1'b0};
          sck_n    = 1'b0;
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BIT_LAST) begin
            mosi_n  = 1'b0;
            state_n = S_HOLD;
          end else begin
            mosi_n  = tx_shift[BUFFER_SIZE-2];
            state_n = S_LOW;
          end
        end else cnt_n = cnt + 16'd1;
      end
      S_HOLD: begin
        sck_n = 1'b0;
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          ssel_n  = 1'b1;
          state_n = S_GAP;
          if (rx_shift[BUFFER_SIZE-1 -: 32] == MSGID) begin
            rxd_n    = rx_shift;
            rxv_n    = 1'b1;
            frame_ok = 1'b1;
          end else ferr_n = 1'b1;
        end else cnt_n = cnt + 16'd1;
      end
      S_GAP: begin
        ssel_n = 1'b1;
        mosi_n = 1'b0;
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else cnt_n = cnt + 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_interface_spimaster.sv
// Scoreboard bench for interface_spimaster: loopback and behavioural-slave frames, reset abort, start flooding, timeout.
module tb_interface_spimaster;
  localparam logic [63:0] F1 = 64'h74697277_12345678;
  localparam logic [63:0] FB = 64'hDEADBEEF_12345678;
  localparam logic [63:0] F2 = 64'h74697277_CAFEF00D;
  localparam logic [63:0] SV = 64'h74697277_00000ABC;
  localparam logic [63:0] TD = 64'hC3C35A5A_0F0FF0F0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interface_spimaster_if #(.BUFFER_SIZE(64)) bus ();
  logic sck, ssel, mosi, miso, pkg_timeout;

  interface_spimaster #(
    .BUFFER_SIZE(64), .MSGID(32'h74697277), .CLK_DIV(4), .CS_SETUP(2),
    .CS_HOLD(2), .GAP(8), .TIMEOUT(32'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .SPI_SCK(sck), .SPI_SSEL(ssel),
    .SPI_MOSI(mosi), .SPI_MISO(miso), .pkg_timeout(pkg_timeout)
  );

  typedef struct {
    logic        err;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        loop = 1'b1;
  logic [63:0] slave_val = '0;
  logic [63:0] slave_tx = '0;
  logic [63:0] slave_rx = '0;
  assign miso = loop ? mosi : slave_tx[63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no event within bound required event", name);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (bus.rx_valid || bus.frame_error)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got rx_valid=%0b frame_error=%0b required none", bus.rx_valid, bus.frame_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_kind", {62'd0, bus.rx_valid, bus.frame_error}, e.err ? 64'd1 : 64'd2);
        check("sb_rx_data", bus.rx_data, e.data);
      end
    end
  end

  // SPI line monitor and behavioural slave
  logic prev_sck = 1'b0, prev_ssel = 1'b1, prev_mosi = 1'b0;
  logic active = 1'b0, rise_seen = 1'b0;
  int fall_cyc = 0, rise_cyc = 0, rises = 0, frames = 0, glitches = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (prev_ssel && !ssel) begin
        if (rise_seen) check("gap_ge_8", 64'(cyc - rise_cyc >= 8), 64'd1);
        fall_cyc = cyc;
        rises = 0;
        active = 1'b1;
        slave_rx = '0;
        slave_tx = slave_val;
        frames++;
      end
      if (!prev_sck && sck) begin
        rises++;
        slave_rx = {slave_rx[62:0], mosi};
        if (mosi !== prev_mosi) glitches++;
      end
      if (prev_sck && sck && mosi !== prev_mosi) glitches++;
      if (prev_sck && !sck) slave_tx = {slave_tx[62:0], 1'b0};
      if (!prev_ssel && ssel && active) begin
        check("ssel_low_cycles", 64'(cyc - fall_cyc), 64'd516);
        check("sck_rises", 64'(rises), 64'd64);
        rise_cyc = cyc;
        rise_seen = 1'b1;
        active = 1'b0;
      end
    end
    prev_sck = sck;
    prev_ssel = ssel;
    prev_mosi = mosi;
  end

  task automatic pulse_start(input logic [63:0] d);
    bus.tx_data = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_idle");
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_rx_valid");
  endtask

  initial begin
    bit ok;
    int f0, c0, r0;
    bus.start = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sck", sck, 0);
    check("rst_ssel", ssel, 1);
    check("rst_mosi", mosi, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_frame_error", bus.frame_error, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pkg_timeout", pkg_timeout, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Abort a frame part way through with reset
    pulse_start(F1);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rises >= 20) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_bit20");
    rst_n = 1'b0;
    #1;
    check("abort_ssel", ssel, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_rx_data", bus.rx_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback, valid MSGID
    check("pre_pkg_timeout", pkg_timeout, 1);
    exp_q.push_back('{err: 1'b0, data: F1});
    pulse_start(F1);
    wait_rx(ok);
    if (ok) check("valid_drops_timeout", pkg_timeout, 0);
    wait_idle();
    check("loop_mosi_bits", slave_rx, F1);

    // Loopback, bad MSGID keeps previous rx_data
    exp_q.push_back('{err: 1'b1, data: F1});
    pulse_start(FB);
    wait_idle();
    check("bad_keeps_rx_data", bus.rx_data, F1);

    // Behavioural slave
    loop = 1'b0;
    slave_val = SV;
    exp_q.push_back('{err: 1'b0, data: SV});
    pulse_start(TD);
    wait_idle();
    check("slave_mosi_bits", slave_rx, TD);
    check("mosi_stable", 64'(glitches), 0);
    loop = 1'b1;

    // start held through one frame: only one frame runs
    exp_q.push_back('{err: 1'b0, data: F2});
    f0 = frames;
    r0 = rise_cyc;
    bus.tx_data = F2;
    bus.start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rise_cyc != r0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_ssel_rise");
    bus.start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("held_start_frames", 64'(frames - f0), 1);

    // start held across frame end: back-to-back with gap
    exp_q.push_back('{err: 1'b0, data: F2});
    exp_q.push_back('{err: 1'b0, data: F2});
    f0 = frames;
    bus.start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frames - f0 >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_second_frame");
    bus.start = 1'b0;
    wait_idle();

    // Timeout: rises exactly 100 cycles after the rx_valid cycle
    repeat (150) @(negedge clk);
    exp_q.push_back('{err: 1'b0, data: F1});
    pulse_start(F1);
    wait_rx(ok);
    c0 = cyc;
    if (ok) check("timeout_cleared", pkg_timeout, 0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pkg_timeout) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_pkg_timeout");
    else check("timeout_delay", 64'(cyc - c0), 100);

    wait_idle();
    repeat (5) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 0);
    check("mosi_stable_all", 64'(glitches), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
